// File: rtl/cs161_mc_datapath.sv
// Multi-cycle MIPS-subset datapath with integrated FETCH/DECODE/EXEC/MEM/WB controller.
// A single memory port serves both instruction fetch and data access, stalling on mem_ready.
module cs161_mc_datapath #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = {ADDR_WIDTH{1'b0}}
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready,
    output logic [ADDR_WIDTH-1:0] prog_count,
    output logic [5:0]            instr_opcode,
    output logic [4:0]            reg1_addr,
    output logic [4:0]            reg2_addr,
    output logic [DATA_WIDTH-1:0] reg1_data,
    output logic [DATA_WIDTH-1:0] reg2_data,
    output logic [4:0]            write_reg_addr,
    output logic [DATA_WIDTH-1:0] write_reg_data,
    output logic                  reg_write_en,
    output logic [2:0]            state,
    output logic                  retire
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] F_ADD    = 6'h20;
    localparam logic [5:0] F_SUB    = 6'h22;
    localparam logic [5:0] F_AND    = 6'h24;
    localparam logic [5:0] F_OR     = 6'h25;
    localparam logic [5:0] F_SLT    = 6'h2A;

    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [31:0]           ir_q, ir_d;
    logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d;
    logic [DATA_WIDTH-1:0] aluout_q, aluout_d, mdr_q, mdr_d;
    logic [DATA_WIDTH-1:0] rf_q [32];

    logic [5:0]            opcode_s, funct_s;
    logic [4:0]            rs_s, rt_s, rd_s;
    logic                  is_rtype_s, is_addi_s, is_lw_s, is_sw_s, is_beq_s;
    logic                  funct_ok_s, supported_s;
    logic [DATA_WIDTH-1:0] rd1_s, rd2_s, alu_res_s;
    logic [ADDR_WIDTH-1:0] br_off_s, alu_addr_s;

    assign opcode_s    = ir_q[31:26];
    assign rs_s        = ir_q[25:21];
    assign rt_s        = ir_q[20:16];
    assign rd_s        = ir_q[15:11];
    assign funct_s     = ir_q[5:0];
    assign is_rtype_s  = (opcode_s == OP_RTYPE);
    assign is_addi_s   = (opcode_s == OP_ADDI);
    assign is_lw_s     = (opcode_s == OP_LW);
    assign is_sw_s     = (opcode_s == OP_SW);
    assign is_beq_s    = (opcode_s == OP_BEQ);
    assign supported_s = (is_rtype_s && funct_ok_s) || is_addi_s || is_lw_s || is_sw_s || is_beq_s;

    assign rd1_s      = (rs_s == 5'd0) ? {DATA_WIDTH{1'b0}} : rf_q[rs_s];
    assign rd2_s      = (rt_s == 5'd0) ? {DATA_WIDTH{1'b0}} : rf_q[rt_s];
    assign br_off_s   = ADDR_WIDTH'($signed({ir_q[15:0], 2'b00}));
    assign alu_addr_s = ADDR_WIDTH'(aluout_q);

    // R-type funct whitelist; anything else on opcode 0 retires as a NOP.
    always_comb begin
        funct_ok_s = 1'b0;
        case (funct_s)
            F_ADD, F_SUB, F_AND, F_OR, F_SLT: funct_ok_s = 1'b1;
            default:                          funct_ok_s = 1'b0;
        endcase
    end

    // ALU: R-type uses A op B; every other instruction computes A + IMM.
    always_comb begin
        alu_res_s = a_q + imm_q;
        if (is_rtype_s) begin
            case (funct_s)
                F_SUB:   alu_res_s = a_q - b_q;
                F_AND:   alu_res_s = a_q & b_q;
                F_OR:    alu_res_s = a_q | b_q;
                F_SLT:   alu_res_s = ($signed(a_q) < $signed(b_q)) ?
                                     {{(DATA_WIDTH-1){1'b0}}, 1'b1} : {DATA_WIDTH{1'b0}};
                default: alu_res_s = a_q + b_q;
            endcase
        end else begin
            alu_res_s = a_q + imm_q;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH:  state_d = mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: state_d = supported_s ? ST_EXEC : ST_FETCH;
            ST_EXEC: begin
                if (is_lw_s || is_sw_s) begin
                    state_d = ST_MEM;
                end else if (is_beq_s) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                if (!mem_ready) begin
                    state_d = ST_MEM;
                end else if (is_sw_s) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_WB:     state_d = ST_FETCH;
            default:   state_d = ST_FETCH;
        endcase
    end

    // Datapath register next-state values, updated only in their owning state.
    always_comb begin
        pc_d     = pc_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        imm_d    = imm_q;
        aluout_d = aluout_q;
        mdr_d    = mdr_q;
        case (state_q)
            ST_FETCH: begin
                if (mem_ready) begin
                    ir_d = mem_rdata[31:0];
                    pc_d = pc_q + ADDR_WIDTH'(32'd4);
                end else begin
                    ir_d = ir_q;
                end
            end
            ST_DECODE: begin
                a_d   = rd1_s;
                b_d   = rd2_s;
                imm_d = DATA_WIDTH'($signed(ir_q[15:0]));
            end
            ST_EXEC: begin
                aluout_d = alu_res_s;
                if (is_beq_s && (a_q == b_q)) begin
                    pc_d = pc_q + br_off_s;
                end else begin
                    pc_d = pc_q;
                end
            end
            ST_MEM: begin
                if (mem_ready && is_lw_s) begin
                    mdr_d = mem_rdata;
                end else begin
                    mdr_d = mdr_q;
                end
            end
            default: pc_d = pc_q;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            ir_q     <= 32'd0;
            a_q      <= {DATA_WIDTH{1'b0}};
            b_q      <= {DATA_WIDTH{1'b0}};
            imm_q    <= {DATA_WIDTH{1'b0}};
            aluout_q <= {DATA_WIDTH{1'b0}};
            mdr_q    <= {DATA_WIDTH{1'b0}};
        end else begin
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            a_q      <= a_d;
            b_q      <= b_d;
            imm_q    <= imm_d;
            aluout_q <= aluout_d;
            mdr_q    <= mdr_d;
        end
    end

    // Register file; r0 is never written so it always reads zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (reg_write_en && (write_reg_addr != 5'd0)) begin
            rf_q[write_reg_addr] <= write_reg_data;
        end
    end

    // FSM outputs; gating mem_req with rst drops it combinationally on an aborted access.
    always_comb begin
        mem_req        = 1'b0;
        mem_we         = 1'b0;
        mem_addr       = pc_q & WORD_MASK;
        reg_write_en   = 1'b0;
        write_reg_addr = 5'd0;
        write_reg_data = {DATA_WIDTH{1'b0}};
        retire         = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_req  = !rst;
                mem_addr = pc_q & WORD_MASK;
            end
            ST_DECODE: retire = !supported_s;
            ST_EXEC:   retire = is_beq_s;
            ST_MEM: begin
                mem_req  = !rst;
                mem_we   = !rst && is_sw_s;
                mem_addr = alu_addr_s & WORD_MASK;
                retire   = is_sw_s && mem_ready;
            end
            ST_WB: begin
                reg_write_en   = 1'b1;
                write_reg_addr = is_rtype_s ? rd_s : rt_s;
                write_reg_data = is_lw_s ? mdr_q : aluout_q;
                retire         = 1'b1;
            end
            default: retire = 1'b0;
        endcase
    end

    assign mem_wdata    = b_q;
    assign prog_count   = pc_q;
    assign instr_opcode = opcode_s;
    assign reg1_addr    = rs_s;
    assign reg2_addr    = rt_s;
    assign reg1_data    = rd1_s;
    assign reg2_data    = rd2_s;
    assign state        = state_q;

endmodule

// File: tb/tb_cs161_mc_datapath.sv
// Directed self-checking bench: a 32-bit core running a small program from a bench memory,
// plus a 64-bit core with RESET_PC=0x100 for reset and wide-datapath checks.
module tb_cs161_mc_datapath;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rst2;

    logic        mem_req, mem_we, mem_ready, reg_write_en, retire;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, prog_count;
    logic [31:0] reg1_data, reg2_data, write_reg_data;
    logic [5:0]  instr_opcode;
    logic [4:0]  reg1_addr, reg2_addr, write_reg_addr;
    logic [2:0]  state;
    logic [31:0] mem [64];

    logic        mem_req2, mem_we2, mem_ready2, reg_write_en2, retire2;
    logic [31:0] mem_addr2, prog_count2;
    logic [63:0] mem_wdata2, mem_rdata2, reg1_data2, reg2_data2, write_reg_data2;
    logic [5:0]  instr_opcode2;
    logic [4:0]  reg1_addr2, reg2_addr2, write_reg_addr2;
    logic [2:0]  state2;

    assign mem_rdata = mem[mem_addr[7:2]];

    cs161_mc_datapath #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .RESET_PC(32'h0)) u_dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .prog_count(prog_count), .instr_opcode(instr_opcode),
        .reg1_addr(reg1_addr), .reg2_addr(reg2_addr),
        .reg1_data(reg1_data), .reg2_data(reg2_data),
        .write_reg_addr(write_reg_addr), .write_reg_data(write_reg_data),
        .reg_write_en(reg_write_en), .state(state), .retire(retire)
    );

    cs161_mc_datapath #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .RESET_PC(32'h100)) u_dut64 (
        .clk(clk), .rst(rst2),
        .mem_req(mem_req2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
        .mem_rdata(mem_rdata2), .mem_ready(mem_ready2),
        .prog_count(prog_count2), .instr_opcode(instr_opcode2),
        .reg1_addr(reg1_addr2), .reg2_addr(reg2_addr2),
        .reg1_data(reg1_data2), .reg2_data(reg2_data2),
        .write_reg_addr(write_reg_addr2), .write_reg_data(write_reg_data2),
        .reg_write_en(reg_write_en2), .state(state2), .retire(retire2)
    );

    int          compared   = 0;
    int          mismatched = 0;
    int          wait_cfg   = 0;
    int          wait_left  = 0;
    logic        wb_seen;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data, dec_r1, dec_r2, we_addr;
    int          we_cyc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs the main core until retire (bounded), serving memory with wait_cfg stall cycles per access.
    task automatic run_instr(input string tag, input int exp_cyc);
        int cyc    = 0;
        int bad_wr = 0;
        bit done   = 1'b0;
        wb_seen = 1'b0;
        we_cyc  = 0;
        we_addr = 32'd0;
        while (!done && cyc < 40) begin
            if (mem_req) begin
                if (wait_left > 0) begin
                    mem_ready = 1'b0;
                    wait_left--;
                end else begin
                    mem_ready = 1'b1;
                    wait_left = wait_cfg;
                end
            end else begin
                mem_ready = 1'b1;
            end
            #1;
            cyc++;
            if (state == 3'd1) begin
                dec_r1 = reg1_data;
                dec_r2 = reg2_data;
            end
            if (reg_write_en) begin
                wb_seen = 1'b1;
                wb_addr = write_reg_addr;
                wb_data = write_reg_data;
            end else if (write_reg_addr != 5'd0 || write_reg_data != 32'd0) begin
                bad_wr++;
            end
            if (mem_req && mem_we) begin
                we_cyc++;
                we_addr = mem_addr;
            end
            if (mem_req && mem_we && mem_ready) begin
                mem[mem_addr[7:2]] = mem_wdata;
            end
            done = retire;
            step();
        end
        chk({tag, ".cycles"}, 64'(cyc), 64'(exp_cyc));
        chk({tag, ".wr_quiet"}, 64'(bad_wr), 64'd0);
    endtask

    initial begin
        rst        = 1'b1;
        rst2       = 1'b1;
        mem_ready  = 1'b1;
        mem_ready2 = 1'b1;
        mem_rdata2 = 64'hDEAD_BEEF_2001_FFFF;
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
        mem[0]  = 32'h2001_0005;  // addi r1,r0,5
        mem[1]  = 32'h2002_FFFD;  // addi r2,r0,-3
        mem[2]  = 32'h0022_1820;  // add  r3,r1,r2
        mem[3]  = 32'h0041_202A;  // slt  r4,r2,r1
        mem[4]  = 32'h1021_FFFE;  // beq  r1,r1,-2
        mem[5]  = 32'h0001_2822;  // sub  r5,r0,r1
        mem[6]  = 32'hAC03_0008;  // sw   r3,8(r0)
        mem[7]  = 32'h8C06_0008;  // lw   r6,8(r0)
        mem[8]  = 32'h2000_0007;  // addi r0,r0,7
        mem[9]  = 32'hFC00_0000;  // opcode 0x3F
        mem[10] = 32'h0006_3820;  // add  r7,r0,r6
        mem[11] = 32'h00A6_4024;  // and  r8,r5,r6
        mem[12] = 32'h00A6_4825;  // or   r9,r5,r6
        mem[13] = 32'hAC01_003C;  // sw   r1,0x3C(r0)
        mem[15] = 32'h1234_5678;

        repeat (3) @(posedge clk);
        #1;
        chk("rst.pc", 64'(prog_count), 64'h0);
        chk("rst.state", 64'(state), 64'd0);
        chk("rst.mem_req", 64'(mem_req), 64'd0);
        chk("rst.retire", 64'(retire), 64'd0);
        chk("rst.rwe", 64'(reg_write_en), 64'd0);
        chk("rst64.pc", 64'(prog_count2), 64'h100);
        chk("rst64.state", 64'(state2), 64'd0);
        chk("rst64.mem_req", 64'(mem_req2), 64'd0);

        // 64-bit core: addi r1,r0,-1 then add r2,r1,r0 to read r1 back.
        rst2 = 1'b0;
        #1;
        chk("rel64.mem_req", 64'(mem_req2), 64'd1);
        chk("rel64.addr", 64'(mem_addr2), 64'h100);
        chk("rel64.we", 64'(mem_we2), 64'd0);
        step();
        chk("w64.decode", 64'(state2), 64'd1);
        chk("w64.pc", 64'(prog_count2), 64'h104);
        chk("w64.op", 64'(instr_opcode2), 64'h08);
        chk("w64.wdata_idle", write_reg_data2, 64'd0);
        step();
        chk("w64.exec", 64'(state2), 64'd2);
        step();
        chk("w64.wb", 64'(state2), 64'd4);
        chk("w64.rwe", 64'(reg_write_en2), 64'd1);
        chk("w64.waddr", 64'(write_reg_addr2), 64'd1);
        chk("w64.wdata", write_reg_data2, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("w64.retire", 64'(retire2), 64'd1);
        mem_rdata2 = 64'h0000_0000_0020_1020;
        step();
        step();
        chk("w64.rd_state", 64'(state2), 64'd1);
        chk("w64.rs", 64'(reg1_addr2), 64'd1);
        chk("w64.r1", reg1_data2, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("w64.r0", reg2_data2, 64'd0);
        chk("w64.rt", 64'(reg2_addr2), 64'd0);
        rst2 = 1'b1;

        // Main core.
        rst = 1'b0;
        #1;
        chk("rel.mem_req", 64'(mem_req), 64'd1);
        chk("rel.addr", 64'(mem_addr), 64'h0);
        chk("rel.we", 64'(mem_we), 64'd0);

        run_instr("addi1", 4);
        chk("addi1.waddr", 64'(wb_addr), 64'd1);
        chk("addi1.wdata", 64'(wb_data), 64'd5);
        run_instr("addi2", 4);
        chk("addi2.waddr", 64'(wb_addr), 64'd2);
        chk("addi2.wdata", 64'(wb_data), 64'hFFFF_FFFD);
        run_instr("add", 4);
        chk("add.rs_data", 64'(dec_r1), 64'd5);
        chk("add.rt_data", 64'(dec_r2), 64'hFFFF_FFFD);
        chk("add.waddr", 64'(wb_addr), 64'd3);
        chk("add.wdata", 64'(wb_data), 64'd2);
        run_instr("slt", 4);
        chk("slt.waddr", 64'(wb_addr), 64'd4);
        chk("slt.wdata", 64'(wb_data), 64'd1);
        run_instr("beq_taken", 3);
        chk("beq_taken.nowb", 64'(wb_seen), 64'd0);
        chk("beq_taken.pc", 64'(prog_count), 64'h0C);
        chk("beq_taken.addr", 64'(mem_addr), 64'h0C);
        mem[4] = 32'h1022_0005;  // beq r1,r2,+5 (operands differ)
        run_instr("slt2", 4);
        chk("slt2.wdata", 64'(wb_data), 64'd1);
        run_instr("beq_nt", 3);
        chk("beq_nt.pc", 64'(prog_count), 64'h14);
        run_instr("sub", 4);
        chk("sub.waddr", 64'(wb_addr), 64'd5);
        chk("sub.wdata", 64'(wb_data), 64'hFFFF_FFFB);

        wait_cfg  = 2;
        wait_left = 2;
        run_instr("sw_wait", 8);
        chk("sw_wait.we_cycles", 64'(we_cyc), 64'd3);
        chk("sw_wait.addr", 64'(we_addr), 64'h8);
        chk("sw_wait.mem", 64'(mem[2]), 64'd2);
        run_instr("lw_wait", 9);
        chk("lw_wait.waddr", 64'(wb_addr), 64'd6);
        chk("lw_wait.wdata", 64'(wb_data), 64'd2);
        wait_cfg  = 0;
        wait_left = 0;

        run_instr("addi_r0", 4);
        chk("addi_r0.waddr", 64'(wb_addr), 64'd0);
        run_instr("nop3f", 2);
        chk("nop3f.nowb", 64'(wb_seen), 64'd0);
        chk("nop3f.pc", 64'(prog_count), 64'h28);
        run_instr("add_r0", 4);
        chk("add_r0.r0", 64'(dec_r1), 64'd0);
        chk("add_r0.r6", 64'(dec_r2), 64'd2);
        chk("add_r0.wdata", 64'(wb_data), 64'd2);
        run_instr("and", 4);
        chk("and.waddr", 64'(wb_addr), 64'd8);
        chk("and.wdata", 64'(wb_data), 64'd2);
        run_instr("or", 4);
        chk("or.waddr", 64'(wb_addr), 64'd9);
        chk("or.wdata", 64'(wb_data), 64'hFFFF_FFFB);

        // sw r1,0x3C(r0) aborted by reset while stalled in MEM.
        mem_ready = 1'b1;
        #1;
        chk("abort.fetch_addr", 64'(mem_addr), 64'h34);
        step();
        step();
        step();
        mem_ready = 1'b0;
        #1;
        chk("abort.mem_state", 64'(state), 64'd3);
        chk("abort.op", 64'(instr_opcode), 64'h2B);
        chk("abort.we", 64'(mem_we), 64'd1);
        chk("abort.addr", 64'(mem_addr), 64'h3C);
        chk("abort.wdata", 64'(mem_wdata), 64'd5);
        step();
        chk("abort.held", 64'(state), 64'd3);
        rst = 1'b1;
        #1;
        chk("abort.req_drop", 64'(mem_req), 64'd0);
        chk("abort.we_drop", 64'(mem_we), 64'd0);
        chk("abort.state", 64'(state), 64'd0);
        chk("abort.pc", 64'(prog_count), 64'h0);
        step();
        rst = 1'b0;
        #1;
        chk("abort.restart_req", 64'(mem_req), 64'd1);
        chk("abort.restart_addr", 64'(mem_addr), 64'h0);
        chk("abort.mem_kept", 64'(mem[15]), 64'h1234_5678);
        run_instr("re_addi1", 4);
        chk("re_addi1.wdata", 64'(wb_data), 64'd5);
        run_instr("re_addi2", 4);
        chk("re_addi2.wdata", 64'(wb_data), 64'hFFFF_FFFD);
        run_instr("bad_funct", 2);
        chk("bad_funct.nowb", 64'(wb_seen), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
